// File: rtl/chaos_cipher_pkg.sv
// Shared types and default widths for the chaotic stream cipher controller.
package chaos_cipher_pkg;

    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_OUT_WIDTH  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WARM,
        RUN,
        DONE
    } ctrlState_t;

endpackage

// File: rtl/cipher_key_slot.sv
// One-entry key buffer with an outstanding-step flag for the key generator.
// Responses are only taken while a step is outstanding; flush drops both.
module cipher_key_slot #(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_issue,
    input  logic                  i_respValid,
    input  logic [DATA_WIDTH-1:0] i_respKey,
    input  logic                  i_fill,
    input  logic                  i_consume,
    output logic                  o_full,
    output logic                  o_outstanding,
    output logic                  o_respTaken,
    output logic [DATA_WIDTH-1:0] o_key
);

    logic                  r_full;
    logic                  r_outstanding;
    logic [DATA_WIDTH-1:0] r_key;
    logic                  w_accept;

    assign w_accept      = i_respValid && r_outstanding;
    assign o_full        = r_full;
    assign o_outstanding = r_outstanding;
    assign o_respTaken   = w_accept;
    assign o_key         = r_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full        <= 1'b0;
            r_outstanding <= 1'b0;
            r_key         <= '0;
        end else if (i_flush) begin
            r_full        <= 1'b0;
            r_outstanding <= 1'b0;
        end else begin
            if (i_issue) begin
                r_outstanding <= 1'b1;
            end else if (w_accept) begin
                r_outstanding <= 1'b0;
            end
            // Warm-up responses clear the flag but never occupy the slot
            if (w_accept && i_fill) begin
                r_full <= 1'b1;
                r_key  <= i_respKey;
            end else if (i_consume) begin
                r_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/chaos_cipher_ctrl.sv
// Frame sequencer for the chaotic stream cipher: seeds and warms the key
// generator, then pairs each accepted plaintext byte with one fresh key word.
module chaos_cipher_ctrl
    import chaos_cipher_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int LEN_WIDTH  = 16,
    parameter int WARM_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [WARM_WIDTH-1:0] warmup,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  byte_cnt,
    input  logic [OUT_WIDTH-1:0]  pt_data,
    input  logic                  pt_valid,
    output logic                  pt_ready,
    output logic                  kg_load,
    output logic [DATA_WIDTH-1:0] kg_seed,
    output logic                  kg_step,
    input  logic [DATA_WIDTH-1:0] kg_key,
    input  logic                  kg_key_valid,
    output logic [OUT_WIDTH-1:0]  xor_plaintext,
    output logic [DATA_WIDTH-1:0] xor_key,
    output logic                  xor_valid
);

    ctrlState_t            r_state;
    ctrlState_t            w_nextState;
    logic [DATA_WIDTH-1:0] r_seed;
    logic [LEN_WIDTH-1:0]  r_frameLen;
    logic [LEN_WIDTH-1:0]  r_byteCnt;
    logic [LEN_WIDTH-1:0]  r_keysReq;
    logic [WARM_WIDTH-1:0] r_warmCnt;
    logic                  r_xorValid;
    logic [OUT_WIDTH-1:0]  r_xorPt;
    logic [DATA_WIDTH-1:0] r_xorKey;
    logic                  w_slotFull;
    logic                  w_outstanding;
    logic                  w_keyResp;
    logic [DATA_WIDTH-1:0] w_slotKey;
    logic                  w_xfer;
    logic                  w_lastByte;
    logic                  w_flush;

    assign w_xfer        = pt_valid && pt_ready && !abort;
    assign w_lastByte    = w_xfer && ((r_byteCnt + LEN_WIDTH'(1)) == r_frameLen);
    // Loading a new seed makes any in-flight key generator response stale
    assign w_flush       = (abort && (r_state != IDLE)) || (r_state == LOAD);
    assign byte_cnt      = r_byteCnt;
    assign kg_seed       = r_seed;
    assign xor_valid     = r_xorValid;
    assign xor_plaintext = r_xorPt;
    assign xor_key       = r_xorKey;

    cipher_key_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_keySlot (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (w_flush),
        .i_issue       (kg_step),
        .i_respValid   (kg_key_valid),
        .i_respKey     (kg_key),
        .i_fill        (r_state == RUN),
        .i_consume     (w_xfer),
        .o_full        (w_slotFull),
        .o_outstanding (w_outstanding),
        .o_respTaken   (w_keyResp),
        .o_key         (w_slotKey)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (abort && (r_state != IDLE)) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_nextState = LOAD;
                LOAD:    w_nextState = (r_warmCnt != '0) ? WARM : RUN;
                WARM:    if (w_keyResp && (r_warmCnt == WARM_WIDTH'(1))) w_nextState = RUN;
                RUN:     if ((r_frameLen == '0) || w_lastByte) w_nextState = DONE;
                DONE:    w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (r_state != IDLE);
        done     = (r_state == DONE);
        kg_load  = 1'b0;
        kg_step  = 1'b0;
        pt_ready = 1'b0;
        case (r_state)
            LOAD: kg_load = !abort;
            WARM: kg_step = !abort && !w_outstanding && (r_warmCnt != '0);
            RUN: begin
                kg_step  = !abort && !w_slotFull && !w_outstanding && (r_keysReq < r_frameLen);
                pt_ready = w_slotFull && (r_byteCnt < r_frameLen);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed     <= '0;
            r_frameLen <= '0;
            r_byteCnt  <= '0;
            r_keysReq  <= '0;
            r_warmCnt  <= '0;
            r_xorValid <= 1'b0;
            r_xorPt    <= '0;
            r_xorKey   <= '0;
        end else begin
            r_xorValid <= w_xfer;
            if (w_xfer) begin
                r_xorPt   <= pt_data;
                r_xorKey  <= w_slotKey;
                r_byteCnt <= r_byteCnt + LEN_WIDTH'(1);
            end
            if ((r_state == IDLE) && start) begin
                r_seed     <= seed;
                r_frameLen <= frame_len;
                r_warmCnt  <= warmup;
                r_byteCnt  <= '0;
                r_keysReq  <= '0;
            end
            if ((r_state == WARM) && w_keyResp && (r_warmCnt != '0)) begin
                r_warmCnt <= r_warmCnt - WARM_WIDTH'(1);
            end
            if ((r_state == RUN) && kg_step) begin
                r_keysReq <= r_keysReq + LEN_WIDTH'(1);
            end
        end
    end

    // The host must hold a stalled byte steady until it is taken
    a_ptStable: assert property (@(posedge clk) disable iff (!rst_n)
        (pt_valid && !pt_ready && !abort) |=> (!pt_valid || $stable(pt_data)));

endmodule

// File: tb/tb_chaos_cipher_ctrl.sv
// Self-checking bench for chaos_cipher_ctrl with a 3-cycle key generator model
// whose key stream is 12'h100 + iteration index since the last seed load.
module tb_chaos_cipher_ctrl;

    typedef struct {
        logic [11:0] seed;
        logic [7:0]  warm;
        logic [15:0] len;
        int          mode;
        bit          midStart;
        bit          spurious;
        logic [7:0]  data [8];
        int          expSteps;
        logic [11:0] firstKey;
    } frameVec_t;

    logic        clk, rst_n, start, abort, pt_valid, pt_ready;
    logic [11:0] seed, kg_seed, kg_key, xor_key;
    logic [15:0] frame_len, byte_cnt;
    logic [7:0]  warmup, pt_data, xor_plaintext;
    logic        busy, done, kg_load, kg_step, kg_key_valid, xor_valid;

    int errors = 0;
    int checks = 0;

    chaos_cipher_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .frame_len(frame_len),
        .warmup(warmup), .abort(abort), .busy(busy), .done(done), .byte_cnt(byte_cnt),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready), .kg_load(kg_load),
        .kg_seed(kg_seed), .kg_step(kg_step), .kg_key(kg_key), .kg_key_valid(kg_key_valid),
        .xor_plaintext(xor_plaintext), .xor_key(xor_key), .xor_valid(xor_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key generator model: fixed 3-cycle latency, in-flight steps dropped on load
    logic        p1, p2, mdlValid, injValid;
    logic [11:0] k1, k2, mdlKey, injKey;
    int          genIdx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= 1'b0; p2 <= 1'b0; mdlValid <= 1'b0;
            k1 <= '0; k2 <= '0; mdlKey <= '0; genIdx <= 0;
        end else if (kg_load) begin
            p1 <= 1'b0; p2 <= 1'b0; mdlValid <= 1'b0; genIdx <= 0;
        end else begin
            p1 <= kg_step;
            k1 <= 12'h100 + 12'(genIdx);
            if (kg_step) genIdx <= genIdx + 1;
            p2 <= p1; k2 <= k1;
            mdlValid <= p2; mdlKey <= k2;
        end
    end

    assign kg_key_valid = mdlValid | injValid;
    assign kg_key       = injValid ? injKey : mdlKey;

    // Monitor: event counters and the observed XOR-stage stream
    int          cycNo = 0, loadCnt = 0, stepCnt = 0, xvCnt = 0, doneCnt = 0, readyCnt = 0;
    int          lastXferCyc = 0, lastDoneCyc = 0;
    bit          doneWithXv = 1'b0;
    logic [11:0] lastLoadSeed = '0;
    logic [19:0] obsQ [$];

    always @(negedge clk) begin
        cycNo++;
        if (rst_n) begin
            if (kg_load) begin loadCnt++; lastLoadSeed = kg_seed; end
            if (kg_step) stepCnt++;
            if (pt_ready) readyCnt++;
            if (pt_valid && pt_ready) lastXferCyc = cycNo;
            if (xor_valid) begin xvCnt++; obsQ.push_back({xor_plaintext, xor_key}); end
            if (done) begin doneCnt++; lastDoneCyc = cycNo; doneWithXv = xor_valid; end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] expKey(input logic [11:0] first, input int i);
        return first + 12'(i);
    endfunction

    function automatic bit validFor(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic applyStimulus(input string tag, input frameVec_t v);
        int  bLoad = loadCnt, bStep = stepCnt, bXv = xvCnt, bDone = doneCnt, bReady = readyCnt;
        int  qBase = obsQ.size();
        int  idx = 0, cyc = 0;
        bit  xfer, finished = 1'b0, midDone = 1'b0;
        if (v.spurious) begin
            @(posedge clk); #1 injValid = 1'b1; injKey = 12'hABC;
            @(posedge clk); #1 injValid = 1'b0;
        end
        @(posedge clk); #1;
        seed = v.seed; frame_len = v.len; warmup = v.warm; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (cyc < 500) begin
            pt_valid = (idx < int'(v.len)) && validFor(v.mode, cyc);
            pt_data  = (idx < int'(v.len)) ? v.data[idx] : 8'h00;
            start    = v.midStart && (idx == 1) && !midDone;
            if (start) midDone = 1'b1;
            @(negedge clk);
            xfer = pt_valid && pt_ready;
            if (!busy) begin finished = 1'b1; break; end
            @(posedge clk); #1;
            if (xfer) idx++;
            cyc++;
        end
        start = 1'b0; pt_valid = 1'b0;
        checkOutput({tag, "_finished"}, 32'(finished), 32'd1);
        checkOutput({tag, "_loads"}, 32'(loadCnt - bLoad), 32'd1);
        checkOutput({tag, "_seed"}, 32'(lastLoadSeed), 32'(v.seed));
        checkOutput({tag, "_steps"}, 32'(stepCnt - bStep), 32'(v.expSteps));
        checkOutput({tag, "_xvalids"}, 32'(xvCnt - bXv), 32'(v.len));
        checkOutput({tag, "_dones"}, 32'(doneCnt - bDone), 32'd1);
        checkOutput({tag, "_bytecnt"}, 32'(byte_cnt), 32'(v.len));
        checkOutput({tag, "_done_xv"}, 32'(doneWithXv), 32'(v.len != 0));
        if (v.len == 0) begin
            checkOutput({tag, "_readycycles"}, 32'(readyCnt - bReady), 32'd0);
        end else begin
            checkOutput({tag, "_donetiming"}, 32'(lastDoneCyc), 32'(lastXferCyc + 1));
        end
        for (int i = 0; i < int'(v.len); i++) begin
            logic [19:0] obs;
            obs = (qBase + i < obsQ.size()) ? obsQ[qBase + i] : 20'hFFFFF;
            checkOutput($sformatf("%s_pair%0d", tag, i), 32'(obs), 32'({v.data[i], expKey(v.firstKey, i)}));
        end
    endtask

    function automatic frameVec_t mkVec(input logic [11:0] s, input logic [7:0] w, input logic [15:0] n,
                                        input int mode, input bit mid, input bit spur);
        frameVec_t v;
        v.seed = s; v.warm = w; v.len = n; v.mode = mode; v.midStart = mid; v.spurious = spur;
        for (int j = 0; j < 8; j++) v.data[j] = 8'($urandom);
        v.expSteps = int'(w) + int'(n);
        v.firstKey = 12'h100 + 12'(w);
        return v;
    endfunction

    frameVec_t vecs [10];

    initial begin
        int cnt, bDone, bXv;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pt_valid = 1'b0; pt_data = '0;
        seed = '0; frame_len = '0; warmup = '0; injValid = 1'b0; injKey = '0;

        vecs[0] = mkVec(12'h5A3, 8'd4, 16'd3, 0, 1'b0, 1'b0);
        vecs[0].data[0] = 8'h11; vecs[0].data[1] = 8'h22; vecs[0].data[2] = 8'h33;
        vecs[1] = vecs[0];
        vecs[1].mode = 1;
        vecs[2] = mkVec(12'h3C7, 8'd2, 16'd0, 0, 1'b0, 1'b0);
        vecs[3] = mkVec(12'h1B2, 8'd1, 16'd4, 0, 1'b1, 1'b0);
        vecs[4] = mkVec(12'h777, 8'd2, 16'd1, 0, 1'b0, 1'b1);
        for (int i = 5; i < 10; i++) begin
            vecs[i] = mkVec(12'($urandom), 8'($urandom_range(0, 5)), 16'($urandom_range(1, 6)), 2, 1'b0, 1'b0);
        end

        #3;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_bytecnt", 32'(byte_cnt), 32'd0);
        checkOutput("rst_ptready", 32'(pt_ready), 32'd0);
        checkOutput("rst_kgload", 32'(kg_load), 32'd0);
        checkOutput("rst_kgseed", 32'(kg_seed), 32'd0);
        checkOutput("rst_kgstep", 32'(kg_step), 32'd0);
        checkOutput("rst_xor", 32'({xor_valid, xor_plaintext, xor_key}), 32'd0);
        #14 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

        // Abort right after the first byte while its follow-up step is in flight
        seed = 12'h5A3; warmup = 8'd1; frame_len = 16'd3;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; pt_valid = 1'b1; pt_data = 8'h11;
        cnt = 0;
        while (!xor_valid && cnt < 100) begin @(negedge clk); cnt++; end
        checkOutput("abort_firstbyte", 32'(xor_valid), 32'd1);
        bDone = doneCnt;
        @(posedge clk); #1 abort = 1'b1; pt_valid = 1'b0;
        @(posedge clk); #1 abort = 1'b0;
        bXv = xvCnt;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_xvalid", 32'(xor_valid), 32'd0);
        checkOutput("abort_bytecnt", 32'(byte_cnt), 32'd1);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        checkOutput("abort_nodone", 32'(doneCnt - bDone), 32'd0);
        checkOutput("abort_stale_xv", 32'(xvCnt - bXv), 32'd0);
        applyStimulus("postabort", mkVec(12'h0F0, 8'd3, 16'd2, 0, 1'b0, 1'b0));

        // Asynchronous reset in the middle of a running frame
        seed = 12'h321; warmup = 8'd0; frame_len = 16'd4;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; pt_valid = 1'b1; pt_data = 8'h5C;
        cnt = 0;
        while (byte_cnt != 16'd2 && cnt < 200) begin @(negedge clk); cnt++; end
        checkOutput("midrst_reach", 32'(byte_cnt), 32'd2);
        #2 rst_n = 1'b0; pt_valid = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_bytecnt", 32'(byte_cnt), 32'd0);
        checkOutput("midrst_kgseed", 32'(kg_seed), 32'd0);
        checkOutput("midrst_strobes", 32'({done, pt_ready, kg_load, kg_step}), 32'd0);
        checkOutput("midrst_xor", 32'({xor_valid, xor_plaintext, xor_key}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("postrst", mkVec(12'($urandom), 8'd3, 16'd5, 2, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
